// File: rtl/ahb3lite_pkg.sv
// AHB3-Lite encodings and the DMA read sequencer state type.
// Shared by rcc_dma_sequencer and rcc_dma_addr_gen.
package ahb3lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        BURST,
        LAST,
        ERR,
        DONE
    } dma_seq_state_t;

    // An INCR burst may not cross a 1KB page without a fresh NONSEQ.
    function automatic logic kb_bound(input logic [9:0] a);
        return a == 10'd0;
    endfunction

endpackage

// File: rtl/rcc_dma_addr_gen.sv
// HADDR register, word increment, 1KB-boundary lookahead and issued-beat
// counter for the RCC DMA read sequencer.
module rcc_dma_addr_gen
    import ahb3lite_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 6
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              load,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              advance,
    output logic [ADDR_W-1:0] haddr,
    output logic [LEN_W:0]    addr_cnt,
    output logic              next_bound
);

    logic [ADDR_W-1:0] haddr_q;
    logic [ADDR_W-1:0] haddr_d;
    logic [ADDR_W-1:0] haddr_inc;
    logic [LEN_W:0]    cnt_q;
    logic [LEN_W:0]    cnt_d;
    logic              unused_lsb;

    assign unused_lsb = ^start_addr[1:0];

    // Wraps modulo 2^ADDR_W by construction.
    assign haddr_inc  = haddr_q + ADDR_W'(4);
    assign next_bound = kb_bound(haddr_inc[9:0]);

    always_comb begin
        haddr_d = haddr_q;
        cnt_d   = cnt_q;
        if (load) begin
            haddr_d = {start_addr[ADDR_W-1:2], 2'b00};
            cnt_d   = '0;
        end else if (advance) begin
            haddr_d = haddr_inc;
            cnt_d   = cnt_q + (LEN_W+1)'(1);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            haddr_q <= '0;
            cnt_q   <= '0;
        end else begin
            haddr_q <= haddr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign haddr    = haddr_q;
    assign addr_cnt = cnt_q;

endmodule

// File: rtl/rcc_dma_sequencer.sv
// AHB3-Lite read sequencer for the RCC DMA command registers.
// Define RCC_DMA_BURST_EN for INCR bursts; default issues SINGLE beats.
module rcc_dma_sequencer
    import ahb3lite_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 6,
    parameter int DATA_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    input  logic              HREADY,
    input  logic              HRESP,
    input  logic [DATA_W-1:0] HRDATA,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              done,
    output logic              error
);

    dma_seq_state_t    state_q, state_d;
    logic [1:0]        htrans_q, htrans_d;
    logic [2:0]        hburst_q, hburst_d;
    logic [LEN_W:0]    len_q, len_d;
    logic [LEN_W:0]    data_cnt_q, data_cnt_d;
    logic [LEN_W:0]    data_cnt_inc;
    logic              dphase_q, dphase_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              cmd_ready_q, cmd_ready_d;

    logic              load;
    logic              accept;
    logic              addr_acc;
    logic              last_addr;
    logic              beat_ok;
    logic              beat_err;
    logic [1:0]        next_trans;
    logic [LEN_W:0]    addr_cnt;
    logic              next_bound;

`ifdef RCC_DMA_BURST_EN
    localparam logic [2:0] BURST_TYPE = HBURST_INCR;
    assign next_trans = next_bound ? HTRANS_NONSEQ : HTRANS_SEQ;
`else
    localparam logic [2:0] BURST_TYPE = HBURST_SINGLE;
    logic unused_bound;
    assign unused_bound = next_bound;
    assign next_trans   = HTRANS_NONSEQ;
`endif

    rcc_dma_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .load       (load),
        .start_addr (cmd_addr),
        .advance    (addr_acc),
        .haddr      (HADDR),
        .addr_cnt   (addr_cnt),
        .next_bound (next_bound)
    );

    // First ERROR cycle: pull HTRANS to IDLE before the slave can accept it.
    assign HTRANS = (dphase_q && HRESP) ? HTRANS_IDLE : htrans_q;

    assign accept       = cmd_valid && cmd_ready_q;
    assign addr_acc     = HREADY && (HTRANS != HTRANS_IDLE);
    assign last_addr    = (addr_cnt + (LEN_W+1)'(1)) == len_q;
    assign beat_ok      = dphase_q && HREADY && !HRESP;
    assign beat_err     = dphase_q && HRESP;
    assign data_cnt_inc = data_cnt_q + (LEN_W+1)'(1);

    always_comb begin
        state_d     = state_q;
        htrans_d    = htrans_q;
        hburst_d    = hburst_q;
        len_d       = len_q;
        data_cnt_d  = data_cnt_q;
        dphase_d    = dphase_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        done_d      = 1'b0;
        error_d     = 1'b0;
        cmd_ready_d = cmd_ready_q;
        load        = 1'b0;

        if (HREADY) begin
            dphase_d = addr_acc;
        end
        if (addr_acc) begin
            htrans_d = last_addr ? HTRANS_IDLE : next_trans;
        end
        if (beat_ok) begin
            rd_valid_d = 1'b1;
            rd_data_d  = HRDATA;
            data_cnt_d = data_cnt_inc;
        end

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    load        = 1'b1;
                    len_d       = {1'b0, cmd_len};
                    data_cnt_d  = '0;
                    cmd_ready_d = 1'b0;
                    if (cmd_len == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = ADDR;
                        htrans_d = HTRANS_NONSEQ;
                        hburst_d = BURST_TYPE;
                    end
                end
            end
            ADDR: begin
                if (addr_acc) begin
                    state_d = last_addr ? LAST : BURST;
                end
            end
            BURST: begin
                if (beat_err) begin
                    state_d  = ERR;
                    htrans_d = HTRANS_IDLE;
                    dphase_d = 1'b0;
                end else if (addr_acc && last_addr) begin
                    state_d = LAST;
                end
            end
            LAST: begin
                if (beat_err) begin
                    state_d  = ERR;
                    htrans_d = HTRANS_IDLE;
                    dphase_d = 1'b0;
                end else if (beat_ok && data_cnt_inc == len_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            ERR: begin
                htrans_d = HTRANS_IDLE;
                dphase_d = 1'b0;
                if (HREADY) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    error_d = 1'b1;
                end
            end
            DONE: begin
                state_d     = IDLE;
                cmd_ready_d = 1'b1;
                hburst_d    = HBURST_SINGLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= IDLE;
            htrans_q    <= HTRANS_IDLE;
            hburst_q    <= HBURST_SINGLE;
            len_q       <= '0;
            data_cnt_q  <= '0;
            dphase_q    <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            htrans_q    <= htrans_d;
            hburst_q    <= hburst_d;
            len_q       <= len_d;
            data_cnt_q  <= data_cnt_d;
            dphase_q    <= dphase_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            done_q      <= done_d;
            error_q     <= error_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign HWRITE    = 1'b0;
    assign HSIZE     = HSIZE_WORD;
    assign HBURST    = hburst_q;
    assign cmd_ready = cmd_ready_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule
